// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions for the modulator and demodulator.
// Provides the symbol type, Gray-coded symbol constants, the sample width,
// the I/Q payload struct and the symbol-to-constellation mapping function.
package qpsk_pkg;

  localparam int unsigned QPSK_W = 5;

  typedef logic [1:0] qpsk_sym_t;

  localparam qpsk_sym_t SYM_00 = 2'b00;
  localparam qpsk_sym_t SYM_01 = 2'b01;
  localparam qpsk_sym_t SYM_11 = 2'b11;
  localparam qpsk_sym_t SYM_10 = 2'b10;

  typedef logic signed [QPSK_W-1:0] qpsk_smp_t;

  typedef struct packed {
    qpsk_smp_t i;
    qpsk_smp_t q;
  } qpsk_iq_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } qpsk_mod_state_t;

  // bit0 picks the I sign, bit1 the Q sign; exact inverse of the sign-bit slicer
  function automatic qpsk_iq_t qpsk_map(input qpsk_sym_t sym, input qpsk_smp_t amp);
    qpsk_iq_t iq;
    iq.i = sym[0] ? -amp : amp;
    iq.q = sym[1] ? -amp : amp;
    return iq;
  endfunction

endpackage

// File: rtl/qpsk_sym_mapper.sv
// Combinational QPSK symbol-to-I/Q mapper.
// Ports:
//   sym  - 2-bit Gray-coded symbol
//   iq_c - signed I/Q constellation point (combinational)
module qpsk_sym_mapper
  import qpsk_pkg::*;
#(
  parameter int unsigned AMP = 11
) (
  input  qpsk_sym_t sym,
  output qpsk_iq_t  iq_c
);

  localparam qpsk_smp_t AMP_S = QPSK_W'(AMP);

  assign iq_c = qpsk_map(sym, AMP_S);

endmodule

// File: rtl/qpsk_mod.sv
// Gray-coded QPSK modulator with a one-symbol holding register.
// Each accepted symbol is emitted as SPS identical signed I/Q samples.
// Ports:
//   clk, rst_n          - sample clock, async active-low reset
//   en                  - transmit enable, honoured at symbol boundaries
//   sym_in/sym_valid    - upstream symbol and its valid
//   sym_ready           - holding register can take sym_in this cycle
//   i_out/q_out         - registered signed samples
//   out_valid           - samples carry a symbol
//   sym_start           - first sample of a symbol
//   underrun            - symbol ended while enabled with nothing queued
module qpsk_mod
  import qpsk_pkg::*;
#(
  parameter int unsigned AMP = 11,
  parameter int unsigned SPS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  qpsk_sym_t                sym_in,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic signed [QPSK_W-1:0] i_out,
  output logic signed [QPSK_W-1:0] q_out,
  output logic                     out_valid,
  output logic                     sym_start,
  output logic                     underrun
);

  localparam int unsigned    CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

  qpsk_mod_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  qpsk_sym_t        pend_q;
  logic             pend_vld_q;

  logic             boundary;
  logic             load;
  logic             accept;

  qpsk_iq_t                 map_iq;
  logic signed [QPSK_W-1:0] i_d, q_d;
  logic                     valid_d, start_d, urun_d;

  qpsk_sym_mapper #(
    .AMP (AMP)
  ) u_mapper (
    .sym  (pend_q),
    .iq_c (map_iq)
  );

  assign boundary = (cnt_q == CNT_LAST);

  // load may coincide with accept, which is what gives SPS=1 full throughput
  assign sym_ready = !pend_vld_q || load;
  assign accept    = sym_valid && sym_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the pend-to-current transfer strobe
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q && en) begin
          load    = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (boundary) begin
          if (en && pend_vld_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Next values of the registered outputs and sample counter
  always_comb begin
    i_d     = '0;
    q_d     = '0;
    valid_d = 1'b0;
    start_d = 1'b0;
    urun_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          i_d     = map_iq.i;
          q_d     = map_iq.q;
          valid_d = 1'b1;
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_TX: begin
        if (!boundary) begin
          i_d     = i_out;
          q_d     = q_out;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(cnt_q + 1'b1);
        end else if (load) begin
          i_d     = map_iq.i;
          q_d     = map_iq.q;
          valid_d = 1'b1;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          // disabled stop is intentional; only an enabled stop is an underrun
          urun_d = en;
          cnt_d  = '0;
        end
      end
    endcase
  end

  // Output, counter and holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out      <= '0;
      q_out      <= '0;
      out_valid  <= 1'b0;
      sym_start  <= 1'b0;
      underrun   <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= SYM_00;
      pend_vld_q <= 1'b0;
    end else begin
      i_out     <= i_d;
      q_out     <= q_d;
      out_valid <= valid_d;
      sym_start <= start_d;
      underrun  <= urun_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        pend_q     <= sym_in;
        pend_vld_q <= 1'b1;
      end else if (load) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_mod.sv
// Self-checking bench for qpsk_mod: scoreboarded samples for an AMP=11/SPS=4
// instance, plus AMP=15 and AMP=1 instances at SPS=1 fed a shared random
// stream and sliced back to symbols by sign.
module tb_qpsk_mod;

  typedef struct {
    int i;
    int q;
    int start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic [1:0]        a_sym;
  logic              a_valid, a_ready, a_vo, a_start, a_urun;
  logic signed [4:0] a_i, a_q;

  // SPS=1 instances sharing one stream
  logic [1:0]        b_sym;
  logic              b_valid, b_ready, b_vo, b_start, b_urun;
  logic              c_ready, c_vo, c_start, c_urun;
  logic signed [4:0] b_i, b_q, c_i, c_q;

  qpsk_mod #(.AMP(11), .SPS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .sym_in(a_sym), .sym_valid(a_valid),
    .sym_ready(a_ready), .i_out(a_i), .q_out(a_q), .out_valid(a_vo),
    .sym_start(a_start), .underrun(a_urun)
  );

  qpsk_mod #(.AMP(15), .SPS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .sym_in(b_sym), .sym_valid(b_valid),
    .sym_ready(b_ready), .i_out(b_i), .q_out(b_q), .out_valid(b_vo),
    .sym_start(b_start), .underrun(b_urun)
  );

  qpsk_mod #(.AMP(1), .SPS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .sym_in(b_sym), .sym_valid(b_valid),
    .sym_ready(c_ready), .i_out(c_i), .q_out(c_q), .out_valid(c_vo),
    .sym_start(c_start), .underrun(c_urun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int amp_of(input logic sgn, input int amp);
    return sgn ? -amp : amp;
  endfunction

  exp_t       exp_a[$];
  int         a_starts[$];
  int         a_urun_n = 0;
  int         acc_cyc = 0;
  logic [1:0] exp_b[$];
  int         b_cnt = 0;
  int         b_first = -1;
  int         b_last = -1;

  // main instance monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_vo) begin
        if (exp_a.size() == 0) begin
          chk("a_extra_sample", 1, 0);
        end else begin
          e = exp_a.pop_front();
          chk("a_i", int'(a_i), e.i);
          chk("a_q", int'(a_q), e.q);
          chk("a_start", int'(a_start), e.start);
        end
        if (a_start) a_starts.push_back(cyc);
      end else begin
        chk("a_idle_i", int'(a_i), 0);
        chk("a_idle_q", int'(a_q), 0);
        chk("a_idle_start", int'(a_start), 0);
      end
      if (a_urun) begin
        a_urun_n++;
        chk("a_urun_outvalid", int'(a_vo), 0);
      end
    end
  end

  // SPS=1 monitor with sign-bit slicing back to symbols
  always @(negedge clk) begin
    logic [1:0] s;
    logic [1:0] demod;
    if (rst_n) begin
      chk("c_valid_vs_b", int'(c_vo), int'(b_vo));
      chk("c_ready_vs_b", int'(c_ready), int'(b_ready));
      if (b_vo) begin
        if (exp_b.size() == 0) begin
          chk("b_extra_sample", 1, 0);
        end else begin
          s = exp_b.pop_front();
          chk("b_i", int'(b_i), amp_of(s[0], 15));
          chk("b_q", int'(b_q), amp_of(s[1], 15));
          chk("c_i", int'(c_i), amp_of(s[0], 1));
          chk("c_q", int'(c_q), amp_of(s[1], 1));
          chk("b_start", int'(b_start), 1);
          if (s[0]) chk("b_neg15_bits", {27'd0, b_i}, 17);
          demod = {b_q < 0, b_i < 0};
          chk("b_loopback", int'(demod), int'(s));
          demod = {c_q < 0, c_i < 0};
          chk("c_loopback", int'(demod), int'(s));
        end
        if (b_first < 0) b_first = cyc;
        b_last = cyc;
        b_cnt++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // present one symbol to dut_a; on acceptance queue its SPS expected samples
  task automatic send_a(input logic [1:0] sym);
    int t;
    a_sym   = sym;
    a_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!a_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) begin
      chk("a_accept_timeout", 0, 1);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    acc_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_a.push_back('{i: amp_of(sym[0], 11), q: amp_of(sym[1], 11),
                        start: (k == 0) ? 1 : 0});
    end
  endtask

  initial begin
    int u0;
    int t;
    rst_n   = 1'b0;
    en      = 1'b1;
    a_sym   = 2'b00;
    a_valid = 1'b0;
    b_sym   = 2'b00;
    b_valid = 1'b0;

    // reset values
    #3;
    chk("rst_i", int'(a_i), 0);
    chk("rst_q", int'(a_q), 0);
    chk("rst_out_valid", int'(a_vo), 0);
    chk("rst_sym_start", int'(a_start), 0);
    chk("rst_underrun", int'(a_urun), 0);
    chk("rst_sym_ready", int'(a_ready), 1);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);

    // single symbol then underrun
    a_starts.delete();
    u0 = a_urun_n;
    send_a(2'b00);
    wait_cyc(10);
    chk("t1_starts", a_starts.size(), 1);
    if (a_starts.size() > 0) chk("t1_latency", a_starts[0] - acc_cyc, 1);
    chk("t1_underruns", a_urun_n - u0, 1);
    chk("t1_queue_empty", exp_a.size(), 0);

    // four symbols back to back
    a_starts.delete();
    u0 = a_urun_n;
    send_a(2'b00);
    send_a(2'b01);
    @(negedge clk);
    chk("t2_ready_low_pend_full", int'(a_ready), 0);
    send_a(2'b11);
    send_a(2'b10);
    wait_cyc(12);
    chk("t2_starts", a_starts.size(), 4);
    for (int k = 1; k < a_starts.size(); k++) chk("t2_start_spacing", a_starts[k] - a_starts[k-1], 4);
    chk("t2_underruns", a_urun_n - u0, 1);
    chk("t2_queue_empty", exp_a.size(), 0);

    // en dropped mid-symbol with a symbol pending
    u0 = a_urun_n;
    send_a(2'b01);
    send_a(2'b11);
    wait_cyc(1);
    en = 1'b0;
    wait_cyc(10);
    chk("t3_no_underrun", a_urun_n - u0, 0);
    chk("t3_pend_kept_queue", exp_a.size(), 4);
    chk("t3_pend_kept_ready", int'(a_ready), 0);
    chk("t3_idle_valid", int'(a_vo), 0);
    en = 1'b1;
    wait_cyc(10);
    chk("t3_resume_drained", exp_a.size(), 0);
    chk("t3_resume_underrun", a_urun_n - u0, 1);

    // async reset mid-symbol with pend full
    u0 = a_urun_n;
    send_a(2'b11);
    send_a(2'b10);
    wait_cyc(1);
    rst_n = 1'b0;
    #1;
    chk("t4_async_i", int'(a_i), 0);
    chk("t4_async_q", int'(a_q), 0);
    chk("t4_async_valid", int'(a_vo), 0);
    chk("t4_async_ready", int'(a_ready), 1);
    exp_a.delete();
    a_starts.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("t4_no_stale_symbol", a_starts.size(), 0);
    chk("t4_no_underrun", a_urun_n - u0, 0);

    // SPS=1 continuous random stream, AMP=15 and AMP=1
    b_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      b_sym = 2'($urandom_range(0, 3));
      t = 0;
      @(negedge clk);
      while (!b_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!b_ready) begin
        chk("b_accept_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
      exp_b.push_back(b_sym);
    end
    b_valid = 1'b0;
    wait_cyc(10);
    chk("b_sample_count", b_cnt, 100);
    chk("b_no_bubbles", b_last - b_first, 99);
    chk("b_queue_empty", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qpsk_mod.md
Name: qpsk_mod

Overview:
Gray-coded QPSK modulator, the transmit-side counterpart of the team's sign-bit QPSK demodulator. Accepts 2-bit symbols over a valid/ready handshake and buffers one symbol ahead. Emits each symbol as SPS identical signed 5-bit I/Q samples at the sample clock, for the DAC or for the loopback into the demodulator. Its constellation is the exact inverse of the demodulator's decision regions, so a noiseless loopback returns the transmitted symbols.

Parameters:
AMP, 11, constellation magnitude applied to I and Q; legal range 1..15.
SPS, 4, output samples per symbol; legal range >= 1.

Ports:
clk  in  1  sample clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  transmit enable; low stops at the next symbol boundary
sym_in  in  2  symbol to transmit; bit0 selects the I sign, bit1 selects the Q sign
sym_valid  in  1  sym_in is valid
sym_ready  out  1  modulator can accept sym_in this cycle
i_out  out  5  signed I sample
q_out  out  5  signed Q sample
out_valid  out  1  i_out/q_out carry a symbol sample
sym_start  out  1  first sample of a symbol
underrun  out  1  one-cycle pulse: symbol ended while en=1 with no next symbol

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset values:
  - i_out=0, q_out=0.
  - out_valid, sym_start and underrun all 0.
  - State IDLE, sample counter 0, holding register empty.
  - sym_ready may be 1 combinationally while in reset release.
- Mapping (the inverse of the demodulator):
  - 00 -> (+AMP,+AMP)
  - 01 -> (-AMP,+AMP)
  - 11 -> (-AMP,-AMP)
  - 10 -> (+AMP,-AMP)
  - I = bit0 ? -AMP : +AMP; Q = bit1 ? -AMP : +AMP.
  - The negation is exact two's complement in 5 bits; no saturation is needed within the legal AMP range.
- Holding register:
  - One entry, pend, with flag pend_vld.
  - sym_ready = !pend_vld || load, where load is the cycle in which pend transfers into the current symbol. sym_ready is combinational from state only and never depends on sym_valid.
  - Accept happens when sym_valid && sym_ready.
  - If accept and load occur in the same cycle, the new symbol replaces pend and pend_vld stays 1.
- State IDLE:
  - out_valid=0 and i_out=q_out=0.
  - Load when pend_vld && en: register the mapped pend into i_out/q_out, set out_valid=1 and sym_start=1, set cnt=0, go to TX.
  - Latency: accept at edge N, first sample visible after edge N+1.
- State TX:
  - out_valid=1 every cycle; cnt increments each cycle.
  - At cnt==SPS-1 (symbol boundary), the outcome depends on en and pend_vld:
    - en && pend_vld: load the next symbol with no gap, cnt=0, sym_start=1.
    - en && !pend_vld: go to IDLE and pulse underrun=1 for the cycle in which outputs return to 0.
    - !en: go to IDLE, keep pend, no underrun pulse.
  - A deassertion of en mid-symbol never truncates the symbol.
- Counter:
  - Width max(1,$clog2(SPS)).
  - SPS=1 means every cycle is a boundary; continuous 1-symbol/cycle throughput is required when sym_valid is held high.
- sym_start and underrun are registered alongside the samples.
- sym_valid while sym_ready=0: hold. The upstream block must keep sym_in stable; no data is lost.
- Asynchronous reset mid-symbol: outputs go to 0 immediately and pend is discarded.

Decomposition:
- Shared package qpsk_pkg, used by both modulator and demodulator:
  - qpsk_sym_t, a 2-bit symbol type.
  - Constants SYM_00, SYM_01, SYM_11, SYM_10.
  - Sample width constant QPSK_W=5.
  - Function qpsk_map(sym, amp) returning the I/Q pair.
- Sub-module qpsk_sym_mapper: combinational symbol-to-I/Q mapper, instantiated once in qpsk_mod and reusable by the demodulator's test bench as a golden model.

Test Plan:
- Reset release, then sym_in=00 valid for one cycle (AMP=11, SPS=4) -> 2 cycles later 4 samples of (+11,+11); sym_start on the first; then underrun pulse and (0,0) with out_valid=0.
- Stream 00,01,11,10 back-to-back with sym_valid high -> 16 contiguous samples (+11,+11)x4, (-11,+11)x4, (-11,-11)x4, (+11,-11)x4; sym_start every 4th cycle; sym_ready low while pend is full.
- Drop en during the 2nd sample of symbol 01 with 11 pending -> 01 completes all 4 samples, then IDLE with no underrun and pend kept; re-raise en -> 11 is emitted next.
- SPS=1, continuous valid stream of 100 random symbols -> one sample per cycle, no bubbles; the loopback through the demodulator reproduces the symbol sequence.
- rst_n asserted mid-symbol with pend full -> outputs 0 asynchronously; after release, no stale symbol is emitted.
- AMP=15 and AMP=1 -> I/Q = ±15 and ±1 exactly; -15 is 5'b10001.
